addr_rf_stream: RTL and testbench
=================================

Name: addr_rf_stream

Overview:
- Parametrised successor to the kernel-to-RF address generator.
- Walks a compressed kernel description: NGRP groups, each with a kernel row offset r, a channel index k and a cumulative end pointer ptr.
- Emits one (row, col, ch) address entry per nonzero over a valid/ready stream instead of a flat RF array.
- Adds empty-group skipping, out-of-bounds detection and drop, input validation, and downstream backpressure. Sits between the sparse-weight loader and the PE input-address FIFO.

Parameters:
NGRP, 4, number of kernel groups (row/channel pairs)
PW, 11, pointer, index and length width
CW, 7, feature-map coordinate width (h, w, row, col)
RW, 3, kernel offset width (r, s)
KW, 5, channel index width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  job start, sampled only in IDLE
i_h  in  CW  current output row coordinate
i_w  in  CW  current output column coordinate
i_s  in  RW  kernel column offset, common to the whole job
i_r  in  NGRP*RW  packed per-group row offsets; group g at [g*RW +: RW]
i_k  in  NGRP*KW  packed per-group channel indices
i_ptr  in  NGRP*PW  packed cumulative end pointers; group g owns indices [ptr[g-1], ptr[g]), with ptr[-1]=0
i_length  in  PW  total entries to generate
i_skip_oob  in  1  1 = drop out-of-bounds entries
o_busy  out  1  high from the cycle after start until o_finish
o_valid  out  1  output entry valid
i_ready  in  1  downstream accepts the entry
o_row  out  CW  i_h - r[g]
o_col  out  CW  i_w - i_s
o_ch  out  KW  k[g]
o_idx  out  PW  entry index
o_oob  out  1  entry is out of bounds (h<r[g] or w<s)
o_last  out  1  entry has idx == length-1
o_finish  out  1  one-cycle pulse at job end
o_err  out  1  sticky configuration error for the last job
o_count  out  PW  entries transferred in the current or last job

Behaviour:
- Reset (asynchronous, i_rst=1): state IDLE, all outputs 0, internal idx=0, latched config cleared. Reset asserted mid-job aborts the job; no finish pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE + i_start:
  - Latch all config inputs; config inputs are don't-care afterwards.
  - Clear o_err and o_count.
  - Validate: ptr must be non-decreasing and i_length <= ptr[NGRP-1].
  - Failure: set o_err, go to DONE.
  - i_length==0: go to DONE, o_err=0.
  - Otherwise: go to RUN with idx=0.
- RUN:
  - Group select is combinational: g = number of j with ptr[j] <= idx. Empty groups are skipped with zero cycle cost.
  - Output register loads when !o_valid || i_ready (registered valid/ready, full throughput).
  - On load with oob=1 and skip_oob=1: the entry is not presented (o_valid=0 for that slot) and idx still advances; one cycle is consumed per dropped entry.
  - Otherwise: o_valid=1 with fields computed on the CW-bit two's-complement wrap; o_oob reports the bound check.
  - o_valid and all fields hold stable while i_ready=0.
  - o_count increments on each o_valid && i_ready.
  - When idx==length-1 is loaded (emitted or dropped): stop loading. Go to DONE once no valid entry remains un-accepted.
  - Entries are never dropped by backpressure.
- DONE: o_finish=1 for exactly one cycle; o_busy falls in the same cycle; go to IDLE.
- o_last is asserted only on an emitted entry with idx==length-1. If that entry is dropped, no o_last is produced; o_finish still marks job end.
- Latency with i_ready held high: start at edge E0 gives the first o_valid after E1. Sustained rate is 1 entry/cycle. o_finish follows the last handshake by 1 cycle.
- i_start while busy is ignored. o_err and o_count hold until the next accepted start.

Test Plan:
- NGRP=4, ptr={2,3,5,6}, r={0,1,2,3}, k={4,5,6,7}, h=10, w=8, s=1, length=6, ready=1 -> 6 entries on consecutive cycles, row={10,10,9,8,8,7}, col=7, ch={4,4,5,6,6,7}, o_last on idx5, finish 1 cycle later, count=6.
- ptr={0,0,3,3}, length=3 -> all 3 entries take group 2 (r[2], k[2]); no bubbles for empty groups.
- Same as case 1 with i_ready toggling 1,0,0,1 -> fields stable through stalls, no loss or duplication, count=6.
- h=1, r={0,2,0,2}, ptr={1,2,3,4}, length=4, skip_oob=1 -> idx0 and idx2 emitted, idx1 and idx3 dropped, no o_last, finish pulses, count=2. Same with skip_oob=0 -> 4 entries, o_oob on idx1/idx3, row=127.
- ptr={3,2,5,6} or length=7 with ptr[3]=6 -> o_err=1, no o_valid, finish 1 cycle after start. length=0 -> finish, o_err=0.
- i_rst pulsed mid-job after 2 transfers -> all outputs 0 immediately, no finish; a new start runs normally from idx0.

Source files
------------

// File: rtl/addr_rf_stream.sv
// Streams one (row, col, ch) RF address per kernel nonzero from a compressed
// group/pointer kernel description, with empty-group skip, OOB drop and backpressure.
module addr_rf_stream #(
  parameter int NGRP = 4,
  parameter int PW   = 11,
  parameter int CW   = 7,
  parameter int RW   = 3,
  parameter int KW   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [CW-1:0]      i_h,
  input  logic [CW-1:0]      i_w,
  input  logic [RW-1:0]      i_s,
  input  logic [NGRP*RW-1:0] i_r,
  input  logic [NGRP*KW-1:0] i_k,
  input  logic [NGRP*PW-1:0] i_ptr,
  input  logic [PW-1:0]      i_length,
  input  logic               i_skip_oob,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [CW-1:0]      o_row,
  output logic [CW-1:0]      o_col,
  output logic [KW-1:0]      o_ch,
  output logic [PW-1:0]      o_idx,
  output logic               o_oob,
  output logic               o_last,
  output logic               o_finish,
  output logic               o_err,
  output logic [PW-1:0]      o_count
);

  localparam int GCW = $clog2(NGRP + 1);
  localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      h_q, w_q;
  logic [RW-1:0]      s_q;
  logic [NGRP*RW-1:0] r_q;
  logic [NGRP*KW-1:0] k_q;
  logic [NGRP*PW-1:0] ptr_q;
  logic [PW-1:0]      len_q;
  logic               skip_q;

  logic [PW-1:0]      idx_p0;
  logic               vld_p0;
  logic [GCW-1:0]     grp_cnt_p0;
  logic [GW-1:0]      grp_p0;
  logic [RW-1:0]      r_p0;
  logic [KW-1:0]      k_p0;
  logic [CW-1:0]      row_p0, col_p0;
  logic               oob_p0, last_p0, drop_p0;

  logic cfg_ok, start_acc, load_en, drain_done, xfer;

  function automatic logic [CW-1:0] wrap_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return a - b;
  endfunction

  function automatic logic below(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return a < b;
  endfunction

  // Job validation on the live inputs, only consumed on an accepted start
  always_comb begin
    cfg_ok = (i_length <= i_ptr[(NGRP-1)*PW +: PW]);
    for (int j = 1; j < NGRP; j++)
      if (i_ptr[j*PW +: PW] < i_ptr[(j-1)*PW +: PW]) cfg_ok = 1'b0;
  end

  // Stage p0: group select by counting exhausted end pointers, so empty groups cost nothing
  always_comb begin
    grp_cnt_p0 = '0;
    for (int j = 0; j < NGRP; j++)
      if (ptr_q[j*PW +: PW] <= idx_p0) grp_cnt_p0 = grp_cnt_p0 + GCW'(1);
    grp_p0 = (grp_cnt_p0 >= GCW'(NGRP)) ? GW'(NGRP - 1) : GW'(grp_cnt_p0);
  end

  assign r_p0    = r_q[grp_p0*RW +: RW];
  assign k_p0    = k_q[grp_p0*KW +: KW];
  assign row_p0  = wrap_sub(h_q, CW'(r_p0));
  assign col_p0  = wrap_sub(w_q, CW'(s_q));
  assign oob_p0  = below(h_q, CW'(r_p0)) || below(w_q, CW'(s_q));
  assign last_p0 = (idx_p0 == len_q - PW'(1));
  assign drop_p0 = oob_p0 && skip_q;

  assign start_acc  = (state_q == S_IDLE) && i_start;
  assign xfer       = o_valid && i_ready;
  assign load_en    = (state_q == S_RUN) && vld_p0 && (!o_valid || i_ready);
  assign drain_done = (state_q == S_RUN) && !vld_p0 && (!o_valid || i_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = (!cfg_ok || i_length == '0) ? S_DONE : S_RUN;
      S_RUN:  if (drain_done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      skip_q  <= 1'b0;
      idx_p0  <= '0;
      vld_p0  <= 1'b0;
      o_err   <= 1'b0;
      o_count <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        h_q     <= i_h;
        w_q     <= i_w;
        s_q     <= i_s;
        r_q     <= i_r;
        k_q     <= i_k;
        ptr_q   <= i_ptr;
        len_q   <= i_length;
        skip_q  <= i_skip_oob;
        idx_p0  <= '0;
        vld_p0  <= cfg_ok && (i_length != '0);
        o_err   <= !cfg_ok;
        o_count <= '0;
      end else begin
        if (load_en) begin
          idx_p0 <= idx_p0 + PW'(1);
          if (last_p0) vld_p0 <= 1'b0;
        end
        if (xfer) o_count <= o_count + PW'(1);
      end
    end
  end

  // Stage p1: output register, refilled whenever it is empty or being accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_row   <= '0;
      o_col   <= '0;
      o_ch    <= '0;
      o_idx   <= '0;
      o_oob   <= 1'b0;
      o_last  <= 1'b0;
    end else if (load_en) begin
      if (drop_p0) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else begin
        o_valid <= 1'b1;
        o_row   <= row_p0;
        o_col   <= col_p0;
        o_ch    <= k_p0;
        o_idx   <= idx_p0;
        o_oob   <= oob_p0;
        o_last  <= last_p0;
      end
    end else if (xfer) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

  assign o_busy   = (state_q == S_RUN);
  assign o_finish = (state_q == S_DONE);

endmodule

// File: tb/tb_addr_rf_stream.sv
// Scoreboard bench for addr_rf_stream: expected entries are generated from the
// job description by walking groups and pointer ranges.
module tb_addr_rf_stream;
  localparam int NGRP = 4, PW = 11, CW = 7, RW = 3, KW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [CW-1:0] i_h = '0, i_w = '0;
  logic [RW-1:0] i_s = '0;
  logic [NGRP*RW-1:0] i_r = '0;
  logic [NGRP*KW-1:0] i_k = '0;
  logic [NGRP*PW-1:0] i_ptr = '0;
  logic [PW-1:0] i_length = '0;
  logic i_skip_oob = 1'b0;
  logic i_ready = 1'b1;
  logic o_busy, o_valid, o_oob, o_last, o_finish, o_err;
  logic [CW-1:0] o_row, o_col;
  logic [KW-1:0] o_ch;
  logic [PW-1:0] o_idx, o_count;

  addr_rf_stream #(.NGRP(NGRP), .PW(PW), .CW(CW), .RW(RW), .KW(KW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_h(i_h), .i_w(i_w), .i_s(i_s),
    .i_r(i_r), .i_k(i_k), .i_ptr(i_ptr), .i_length(i_length), .i_skip_oob(i_skip_oob),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_row(o_row), .o_col(o_col),
    .o_ch(o_ch), .o_idx(o_idx), .o_oob(o_oob), .o_last(o_last), .o_finish(o_finish),
    .o_err(o_err), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [KW-1:0] ch;
    logic [PW-1:0] idx;
    logic          oob;
    logic          last;
  } ent_t;

  ent_t sbq[$];
  int checks = 0;
  int errors = 0;

  int c_r[NGRP], c_k[NGRP], c_ptr[NGRP];
  int c_h, c_w, c_s, c_len;
  bit c_skip;

  task automatic set_case1();
    c_r = '{0, 1, 2, 3};
    c_k = '{4, 5, 6, 7};
    c_ptr = '{2, 3, 5, 6};
    c_h = 10; c_w = 8; c_s = 1; c_len = 6; c_skip = 1'b0;
  endtask

  task automatic apply_cfg();
    for (int g = 0; g < NGRP; g++) begin
      i_r[g*RW +: RW]   = c_r[g][RW-1:0];
      i_k[g*KW +: KW]   = c_k[g][KW-1:0];
      i_ptr[g*PW +: PW] = c_ptr[g][PW-1:0];
    end
    i_h = c_h[CW-1:0];
    i_w = c_w[CW-1:0];
    i_s = c_s[RW-1:0];
    i_length = c_len[PW-1:0];
    i_skip_oob = c_skip;
  endtask

  task automatic build_expected(output int n_exp, output bit exp_err);
    int lo;
    ent_t e;
    bit oob;
    sbq.delete();
    n_exp = 0;
    exp_err = (c_len > c_ptr[NGRP-1]);
    for (int g = 1; g < NGRP; g++) if (c_ptr[g] < c_ptr[g-1]) exp_err = 1'b1;
    if (exp_err) return;
    lo = 0;
    for (int g = 0; g < NGRP; g++) begin
      for (int i = lo; i < c_ptr[g]; i++) begin
        if (i < c_len) begin
          oob = (c_h < c_r[g]) || (c_w < c_s);
          e.row  = CW'(c_h - c_r[g]);
          e.col  = CW'(c_w - c_s);
          e.ch   = KW'(c_k[g]);
          e.idx  = PW'(i);
          e.oob  = oob;
          e.last = (i == c_len - 1);
          if (!(oob && c_skip)) begin
            sbq.push_back(e);
            n_exp++;
          end
        end
      end
      lo = c_ptr[g];
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 1) begin
      case (cyc % 4)
        0: return 1'b1;
        1: return 1'b0;
        2: return 1'b0;
        default: return 1'b1;
      endcase
    end
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Starts a job, scrambles the config inputs, and scoreboards the stream until o_finish.
  task automatic run_job(input int mode, input string tag, input bit exp_run,
                         output int fin_cyc, output int n_acc, output int n_last);
    ent_t got;
    fin_cyc = -1; n_acc = 0; n_last = 0;
    apply_cfg();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_h = CW'($urandom); i_w = CW'($urandom); i_s = RW'($urandom);
    i_r = NGRP*RW'($urandom); i_k = NGRP*KW'($urandom);
    i_ptr = NGRP*PW'($urandom); i_length = PW'($urandom); i_skip_oob = 1'($urandom);
    checks++;
    if (o_busy !== exp_run) begin
      errors++;
      $display("FAIL %s busy_after_start got %0b want %0b", tag, o_busy, exp_run);
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      i_ready = ready_pat(mode, cyc);
      if (o_finish) begin
        fin_cyc = cyc;
        break;
      end
      if (o_valid) begin
        got = '{row: o_row, col: o_col, ch: o_ch, idx: o_idx, oob: o_oob, last: o_last};
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL %s extra_entry got idx %0d want none", tag, o_idx);
        end else begin
          if (got !== sbq[0])
            begin
              errors++;
              $display("FAIL %s entry got row %0d col %0d ch %0d idx %0d oob %0b last %0b want row %0d col %0d ch %0d idx %0d oob %0b last %0b",
                       tag, got.row, got.col, got.ch, got.idx, got.oob, got.last,
                       sbq[0].row, sbq[0].col, sbq[0].ch, sbq[0].idx, sbq[0].oob, sbq[0].last);
            end
          if (i_ready) begin
            void'(sbq.pop_front());
            n_acc++;
            if (o_last) n_last++;
          end
        end
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    checks++;
    if (fin_cyc < 0) begin
      errors++;
      $display("FAIL %s finish_timeout got none want pulse", tag);
    end else if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_finish got %0b want 0", tag, o_busy);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s missing_entries got %0d left want 0", tag, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_valid, o_row, o_col, o_ch, o_idx, o_oob, o_last, o_finish, o_err, o_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid %0b busy %0b count %0d want all 0", o_valid, o_busy, o_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input int mode, input string tag);
    int n_exp, fin, acc, nl;
    bit ee;
    set_case1();
    build_expected(n_exp, ee);
    run_job(mode, tag, 1'b1, fin, acc, nl);
    checks++;
    if (acc != 6 || o_count !== PW'(6)) begin
      errors++;
      $display("FAIL %s count got acc %0d o_count %0d want 6", tag, acc, o_count);
    end
    checks++;
    if (nl != 1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL %s last_err got last %0d err %0b want 1 0", tag, nl, o_err);
    end
    if (mode == 0) begin
      checks++;
      if (fin != 7) begin
        errors++;
        $display("FAIL %s finish_latency got %0d want 7", tag, fin);
      end
    end
  endtask

  task automatic test_empty_groups();
    int n_exp, fin, acc, nl;
    bit ee;
    set_case1();
    c_ptr = '{0, 0, 3, 3};
    c_len = 3;
    build_expected(n_exp, ee);
    run_job(0, "empty_groups", 1'b1, fin, acc, nl);
    checks++;
    if (fin != 4 || acc != 3 || o_count !== PW'(3)) begin
      errors++;
      $display("FAIL empty_groups timing got fin %0d acc %0d count %0d want 4 3 3", fin, acc, o_count);
    end
  endtask

  task automatic test_oob(input bit skip);
    int n_exp, fin, acc, nl;
    bit ee;
    set_case1();
    c_h = 1;
    c_r = '{0, 2, 0, 2};
    c_ptr = '{1, 2, 3, 4};
    c_len = 4;
    c_skip = skip;
    build_expected(n_exp, ee);
    run_job(0, skip ? "oob_skip" : "oob_keep", 1'b1, fin, acc, nl);
    checks++;
    if (acc != (skip ? 2 : 4) || o_count !== PW'(skip ? 2 : 4) || nl != (skip ? 0 : 1)) begin
      errors++;
      $display("FAIL oob skip=%0b got acc %0d count %0d last %0d want %0d %0d %0d", skip, acc, o_count, nl,
               skip ? 2 : 4, skip ? 2 : 4, skip ? 0 : 1);
    end
    if (skip) begin
      checks++;
      if (fin != 5) begin
        errors++;
        $display("FAIL oob_skip finish_cycle got %0d want 5", fin);
      end
    end
  endtask

  task automatic test_errors();
    int n_exp, fin, acc, nl;
    bit ee;
    for (int t = 0; t < 3; t++) begin
      set_case1();
      if (t == 0) c_ptr = '{3, 2, 5, 6};
      if (t == 1) c_len = 7;
      if (t == 2) c_len = 0;
      build_expected(n_exp, ee);
      run_job(0, "cfg_check", 1'b0, fin, acc, nl);
      checks++;
      if (fin != 0 || acc != 0 || o_err !== (t != 2) || o_count !== '0) begin
        errors++;
        $display("FAIL cfg_check case %0d got fin %0d acc %0d err %0b count %0d want 0 0 %0b 0",
                 t, fin, acc, o_err, o_count, t != 2);
      end
      if (t == 1) begin
        repeat (3) @(negedge clk);
        checks++;
        if (o_err !== 1'b1) begin
          errors++;
          $display("FAIL err_sticky got %0b want 1", o_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int n_exp;
    bit ee;
    bit saw_fin;
    set_case1();
    build_expected(n_exp, ee);
    apply_cfg();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_count !== PW'(2)) begin
      errors++;
      $display("FAIL midrst_pre_count got %0d want 2", o_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_valid, o_row, o_col, o_ch, o_idx, o_oob, o_last, o_finish, o_err, o_count} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got valid %0b busy %0b count %0d idx %0d want all 0", o_valid, o_busy, o_count, o_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_fin = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_finish) saw_fin = 1'b1;
    end
    checks++;
    if (saw_fin) begin
      errors++;
      $display("FAIL midrst_no_finish got pulse want none");
    end
    test_basic(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_empty_groups();
    test_basic(1, "backpressure");
    test_basic(2, "random_ready");
    test_oob(1'b1);
    test_oob(1'b0);
    test_errors();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
